// File: rtl/ft245_fifo_responder_if.sv
// FT245-style byte FIFO port plus the USB-core byte streams.
// Valid/ready: a beat transfers on a rising CLK edge where valid and ready are both high;
// the sender holds its data stable while valid is high and ready is low.
interface ft245_fifo_responder_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       nRXF;
  logic       nTXE;
  logic       nRD;
  logic       WR;
  logic [7:0] D_in;
  logic [7:0] D_out;
  logic       D_oe;

  modport slave (
    input  rx_data, rx_valid, tx_ready, nRD, WR, D_in,
    output rx_ready, tx_data, tx_valid, nRXF, nTXE, D_out, D_oe
  );

  modport master (
    output rx_data, rx_valid, tx_ready, nRD, WR, D_in,
    input  rx_ready, tx_data, tx_valid, nRXF, nTXE, D_out, D_oe
  );
endinterface

// File: rtl/ft245_fifo_responder.sv
// Device-side FT245 FIFO port responder: bridges engine nRD/WR strobes to RX/TX byte
// FIFOs fed and drained by valid/ready streams on the USB core side.
module ft245_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;

  // Pointers carry one extra bit so that level = wptr - rptr distinguishes full from empty.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wptr[AW-1:0]] <= din;
  end

  assign head  = mem[rptr[AW-1:0]];
  assign level = wptr - rptr;
  assign empty = (level == '0);
  assign full  = (level == (AW+1)'(DEPTH));
endmodule

module ft245_fifo_responder #(
  parameter int RX_DEPTH = 16,
  parameter int TX_DEPTH = 16
) (
  input  logic                        CLK,
  input  logic                        RST,
  ft245_fifo_responder_if.slave       bus,
  output logic [$clog2(RX_DEPTH):0]   rx_level,
  output logic [$clog2(TX_DEPTH):0]   tx_level,
  output logic                        err_underrun,
  output logic                        err_overrun,
  output logic                        rd_state_dbg
);
  typedef enum logic {RD_IDLE, RD_READING} rd_state_t;

  rd_state_t  rd_state;
  rd_state_t  rd_state_next;
  logic       nrd_q;
  logic       wr_q;
  logic       rd_fall;
  logic       rd_rise;
  logic       wr_fall;
  logic       rx_push;
  logic       rx_pop;
  logic       tx_push;
  logic       tx_pop;
  logic [7:0] rx_head;
  logic [7:0] tx_head;
  logic       rx_empty;
  logic       rx_full;
  logic       tx_empty;
  logic       tx_full;

  // State register: read FSM plus the registered strobe copies used for edge detection.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_state <= RD_IDLE;
      nrd_q    <= 1'b1;
      wr_q     <= 1'b0;
    end else begin
      rd_state <= rd_state_next;
      nrd_q    <= bus.nRD;
      wr_q     <= bus.WR;
    end
  end

  assign rd_fall = nrd_q & ~bus.nRD;
  assign rd_rise = ~nrd_q & bus.nRD;
  assign wr_fall = wr_q & ~bus.WR;

  always_comb begin
    rd_state_next = rd_state;
    case (rd_state)
      RD_IDLE:    if (rd_fall && !rx_empty) rd_state_next = RD_READING;
      RD_READING: if (rd_rise) rd_state_next = RD_IDLE;
      default:    rd_state_next = RD_IDLE;
    endcase
  end

  // The byte leaves the RX FIFO only when the strobe ends, so D_out stays stable throughout.
  always_comb begin
    rx_pop       = 1'b0;
    err_underrun = 1'b0;
    case (rd_state)
      RD_IDLE:    err_underrun = rd_fall & rx_empty & ~RST;
      RD_READING: rx_pop = rd_rise;
      default:    rx_pop = 1'b0;
    endcase
  end

  assign rx_push     = bus.rx_valid & ~rx_full;
  assign tx_push     = wr_fall & ~tx_full;
  assign tx_pop      = ~tx_empty & bus.tx_ready;
  assign err_overrun = wr_fall & tx_full & ~RST;

  assign bus.rx_ready = ~rx_full;
  assign bus.tx_valid = ~tx_empty;
  assign bus.tx_data  = tx_head;
  assign bus.D_oe     = ~bus.nRD;
  assign bus.D_out    = rx_empty ? 8'h00 : rx_head;
  assign bus.nRXF     = rx_empty | ~bus.nRD | rd_rise;
  assign bus.nTXE     = tx_full | bus.WR | wr_fall;
  assign rd_state_dbg = (rd_state == RD_READING);

  ft245_byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (rx_push),
    .din   (bus.rx_data),
    .pop   (rx_pop),
    .head  (rx_head),
    .level (rx_level),
    .empty (rx_empty),
    .full  (rx_full)
  );

  ft245_byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (tx_push),
    .din   (bus.D_in),
    .pop   (tx_pop),
    .head  (tx_head),
    .level (tx_level),
    .empty (tx_empty),
    .full  (tx_full)
  );
endmodule

// File: tb/tb_ft245_fifo_responder.sv
// Bench for ft245_fifo_responder: queue-based model checked every cycle, plus directed
// engine/stream sequences with literal expectations.
module tb_ft245_fifo_responder;
  localparam int RX_DEPTH = 16;
  localparam int TX_DEPTH = 16;

  logic       CLK;
  logic       RST;
  logic [4:0] rx_level;
  logic [4:0] tx_level;
  logic       err_underrun;
  logic       err_overrun;
  logic       rd_state_dbg;

  ft245_fifo_responder_if bus ();

  ft245_fifo_responder #(.RX_DEPTH(RX_DEPTH), .TX_DEPTH(TX_DEPTH)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .bus          (bus),
    .rx_level     (rx_level),
    .tx_level     (tx_level),
    .err_underrun (err_underrun),
    .err_overrun  (err_overrun),
    .rd_state_dbg (rd_state_dbg)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int passed = 0;
  int total  = 0;
  int und_cnt = 0;
  int ovr_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  // Model: byte queues and the engine strobe history
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic       m_nrd_prev;
  logic       m_wr_prev;
  logic       m_reading;

  always @(posedge CLK) begin
    if (RST) begin
      rx_q.delete();
      tx_q.delete();
      m_nrd_prev = 1'b1;
      m_wr_prev  = 1'b0;
      m_reading  = 1'b0;
    end else begin
      automatic bit fell   = m_nrd_prev && !bus.nRD;
      automatic bit rose   = !m_nrd_prev && bus.nRD;
      automatic bit wfell  = m_wr_prev && !bus.WR;
      automatic bit rx_in  = bus.rx_valid && (rx_q.size() < RX_DEPTH);
      automatic bit tx_in  = wfell && (tx_q.size() < TX_DEPTH);
      automatic bit tx_out = (tx_q.size() > 0) && bus.tx_ready;
      automatic bit rx_out = m_reading && rose;
      automatic bit start  = !m_reading && fell && (rx_q.size() > 0);
      if (rx_out) void'(rx_q.pop_front());
      if (tx_out) void'(tx_q.pop_front());
      if (rx_in)  rx_q.push_back(bus.rx_data);
      if (tx_in)  tx_q.push_back(bus.D_in);
      if (rx_out) m_reading = 1'b0;
      if (start)  m_reading = 1'b1;
      m_nrd_prev = bus.nRD;
      m_wr_prev  = bus.WR;
    end
  end

  // Scoreboard compare, every cycle out of reset
  always @(negedge CLK) begin
    if (!RST) begin
      automatic bit fell  = m_nrd_prev && !bus.nRD;
      automatic bit rose  = !m_nrd_prev && bus.nRD;
      automatic bit wfell = m_wr_prev && !bus.WR;
      automatic bit rx_e  = (rx_q.size() == 0);
      automatic bit tx_f  = (tx_q.size() == TX_DEPTH);
      chk("m_rx_level", rx_level, rx_q.size());
      chk("m_tx_level", tx_level, tx_q.size());
      chk("m_rx_ready", bus.rx_ready, rx_q.size() < RX_DEPTH);
      chk("m_tx_valid", bus.tx_valid, !(tx_q.size() == 0));
      if (tx_q.size() > 0) chk("m_tx_data", bus.tx_data, tx_q[0]);
      chk("m_d_out", bus.D_out, rx_e ? 8'h00 : rx_q[0]);
      chk("m_d_oe", bus.D_oe, !bus.nRD);
      chk("m_nrxf", bus.nRXF, rx_e || !bus.nRD || rose);
      chk("m_ntxe", bus.nTXE, tx_f || bus.WR || wfell);
      chk("m_underrun", err_underrun, !m_reading && fell && rx_e);
      chk("m_overrun", err_overrun, wfell && tx_f);
      chk("m_rd_state", rd_state_dbg, m_reading);
      if (err_underrun) und_cnt++;
      if (err_overrun)  ovr_cnt++;
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic stream_push(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic engine_read(output logic [7:0] b);
    bus.nRD = 1'b0;
    @(negedge CLK);
    b = bus.D_out;
    tick();
    tick();
    tick();
    bus.nRD = 1'b1;
    tick();
    tick();
  endtask

  task automatic engine_write(input logic [7:0] b);
    bus.D_in = b;
    bus.WR   = 1'b1;
    tick();
    tick();
    bus.WR = 1'b0;
    tick();
    tick();
  endtask

  logic [7:0] b;
  int ovr0;
  int und0;

  initial begin
    RST = 1'b1;
    bus.rx_data = 8'h00; bus.rx_valid = 1'b0; bus.tx_ready = 1'b0;
    bus.nRD = 1'b1; bus.WR = 1'b0; bus.D_in = 8'h00;
    tick(); tick(); tick();
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_nrxf", bus.nRXF, 1'b1);
    chk("rst_ntxe", bus.nTXE, 1'b0);
    chk("rst_d_oe", bus.D_oe, 1'b0);
    chk("rst_d_out", bus.D_out, 8'h00);
    chk("rst_rx_ready", bus.rx_ready, 1'b1);
    chk("rst_tx_valid", bus.tx_valid, 1'b0);
    chk("rst_levels", {rx_level, tx_level}, 10'd0);
    tick();

    // Single byte through RX and an engine read
    bus.rx_data = 8'hA5; bus.rx_valid = 1'b1;
    @(negedge CLK);
    chk("t1_nrxf_pre", bus.nRXF, 1'b1);
    tick();
    bus.rx_valid = 1'b0;
    @(negedge CLK);
    chk("t1_nrxf_low", bus.nRXF, 1'b0);
    chk("t1_level1", rx_level, 5'd1);
    tick();
    bus.nRD = 1'b0;
    @(negedge CLK);
    chk("t1_d_oe", bus.D_oe, 1'b1);
    chk("t1_d_out", bus.D_out, 8'hA5);
    chk("t1_nrxf_strobe", bus.nRXF, 1'b1);
    tick(); tick(); tick();
    bus.nRD = 1'b1;
    @(negedge CLK);
    chk("t1_rise_level", rx_level, 5'd1);
    chk("t1_rise_nrxf", bus.nRXF, 1'b1);
    tick();
    @(negedge CLK);
    chk("t1_popped", rx_level, 5'd0);
    chk("t1_nrxf_after", bus.nRXF, 1'b1);
    tick();

    // Single engine write
    bus.D_in = 8'h3C; bus.WR = 1'b1;
    @(negedge CLK);
    chk("t2_ntxe_pulse", bus.nTXE, 1'b1);
    tick(); tick();
    bus.WR = 1'b0;
    @(negedge CLK);
    chk("t2_ntxe_fall", bus.nTXE, 1'b1);
    chk("t2_level0", tx_level, 5'd0);
    tick();
    @(negedge CLK);
    chk("t2_level1", tx_level, 5'd1);
    chk("t2_tx_valid", bus.tx_valid, 1'b1);
    chk("t2_tx_data", bus.tx_data, 8'h3C);
    chk("t2_ntxe_low", bus.nTXE, 1'b0);
    tick();
    bus.tx_ready = 1'b1;
    tick();
    bus.tx_ready = 1'b0;
    @(negedge CLK);
    chk("t2_drained", tx_level, 5'd0);
    tick();

    // RX fill to full, two passes so the pointers wrap
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 16; i++) stream_push(8'(pass * 16 + i));
      @(negedge CLK);
      chk("t3_full_level", rx_level, 5'd16);
      chk("t3_full_ready", bus.rx_ready, 1'b0);
      tick();
      for (int i = 0; i < 16; i++) begin
        engine_read(b);
        chk("t3_read_byte", b, 8'(pass * 16 + i));
        if (i == 0) begin
          @(negedge CLK);
          chk("t3_ready_after_pop", bus.rx_ready, 1'b1);
          tick();
        end
      end
    end

    // TX overrun
    for (int i = 0; i < 16; i++) engine_write(8'(8'h40 + i));
    @(negedge CLK);
    chk("t4_full_level", tx_level, 5'd16);
    tick();
    ovr0 = ovr_cnt;
    bus.D_in = 8'hEE; bus.WR = 1'b1;
    @(negedge CLK);
    chk("t4_ntxe_pulse", bus.nTXE, 1'b1);
    tick(); tick();
    bus.WR = 1'b0;
    @(negedge CLK);
    chk("t4_ntxe_fall", bus.nTXE, 1'b1);
    chk("t4_overrun", err_overrun, 1'b1);
    tick();
    @(negedge CLK);
    chk("t4_ntxe_after", bus.nTXE, 1'b1);
    chk("t4_level_kept", tx_level, 5'd16);
    chk("t4_one_pulse", ovr_cnt - ovr0, 1);
    tick();
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      chk("t4_drain_byte", bus.tx_data, 8'(8'h40 + i));
      tick();
    end
    bus.tx_ready = 1'b0;
    @(negedge CLK);
    chk("t4_no_ee", bus.tx_valid, 1'b0);
    tick();

    // Underrun, then a real byte still reads correctly
    und0 = und_cnt;
    engine_read(b);
    chk("t5_d_out_empty", b, 8'h00);
    chk("t5_one_underrun", und_cnt - und0, 1);
    chk("t5_level", rx_level, 5'd0);
    stream_push(8'h77);
    tick();
    engine_read(b);
    chk("t5_next_byte", b, 8'h77);

    // Reset while a read strobe is in progress
    stream_push(8'h81);
    stream_push(8'h82);
    tick();
    bus.nRD = 1'b0;
    tick(); tick();
    chk("t6_reading", rd_state_dbg, 1'b1);
    RST = 1'b1;
    tick(); tick();
    RST = 1'b0;
    tick();
    und0 = und_cnt;
    tick();
    bus.nRD = 1'b1;
    tick(); tick();
    @(negedge CLK);
    chk("t6_rx_level", rx_level, 5'd0);
    chk("t6_tx_level", tx_level, 5'd0);
    chk("t6_nrxf", bus.nRXF, 1'b1);
    chk("t6_no_underrun", und_cnt - und0, 0);
    chk("t6_idle", rd_state_dbg, 1'b0);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
